// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default widths and legal prescale
// values. Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  localparam int PRESCALE_8   = 8;
  localparam int PRESCALE_16  = 16;
  localparam int PRESCALE_32  = 32;
  localparam int PRESCALE_MIN = PRESCALE_8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler for uart_rx. With UART_RX_MAJORITY_VOTE_EN defined it votes over
// three samples around mid-bit; otherwise it takes a single mid-bit sample.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx,
  input  logic                  i_active,
  input  logic [PRESCALE_W-1:0] i_edge_cnt,
  input  logic [PRESCALE_W-1:0] i_half,
  output logic                  o_bit,
  output logic                  o_bit_ready
);

  localparam logic [PRESCALE_W-1:0] W_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] W_TWO = PRESCALE_W'(2);

  logic                  r_bit;
  logic                  r_bit_ready;
  logic [PRESCALE_W-1:0] w_half_m1;
  logic [PRESCALE_W-1:0] w_half_p1;
  logic [PRESCALE_W-1:0] w_half_p2;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [2:0] r_win;
`else
  logic       r_mid;
`endif

  assign w_half_m1 = i_half - W_ONE;
  assign w_half_p1 = i_half + W_ONE;
  assign w_half_p2 = i_half + W_TWO;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit       <= 1'b1;
      r_bit_ready <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      r_win       <= 3'b111;
`else
      r_mid       <= 1'b1;
`endif
    end else begin
      r_bit_ready <= 1'b0;
      if (i_active) begin
`ifdef UART_RX_MAJORITY_VOTE_EN
        if (i_edge_cnt == w_half_m1) r_win[0] <= i_rx;
        if (i_edge_cnt == i_half)    r_win[1] <= i_rx;
        if (i_edge_cnt == w_half_p1) r_win[2] <= i_rx;
        if (i_edge_cnt == w_half_p2) begin
          r_bit       <= majority3(r_win);
          r_bit_ready <= 1'b1;
        end
`else
        if (i_edge_cnt == i_half) r_mid <= i_rx;
        if (i_edge_cnt == w_half_p1) begin
          r_bit       <= r_mid;
          r_bit_ready <= 1'b1;
        end
`endif
      end
    end
  end

  assign o_bit       = r_bit;
  assign o_bit_ready = r_bit_ready;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / DATA_WIDTH data bits LSB first / optional parity / stop.
// Sampling mode is selected by UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
  localparam logic [PRESCALE_W-1:0] W_ONE    = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] W_PMIN   = PRESCALE_W'(PRESCALE_MIN);

  uart_state_t           r_state;
  uart_state_t           w_next_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fail;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;

  logic [PRESCALE_W-1:0] w_p;
  logic [PRESCALE_W-1:0] w_half;
  logic                  w_last;
  logic                  w_active;
  logic                  w_bit;
  logic                  w_bit_ready;
  logic                  w_start;
  logic                  w_dv_next;
  logic                  w_pe_next;
  logic                  w_se_next;

  // Clamping keeps the bit period long enough for the sample window and
  // guarantees edge_cnt always wraps, whatever Prescale was latched.
  assign w_p      = (r_prescale < W_PMIN) ? W_PMIN : r_prescale;
  assign w_half   = w_p >> 1;
  assign w_last   = (r_edge_cnt >= (w_p - W_ONE));
  assign w_active = (r_state != IDLE);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (RX_IN),
    .i_active    (w_active),
    .i_edge_cnt  (r_edge_cnt),
    .i_half      (w_half),
    .o_bit       (w_bit),
    .o_bit_ready (w_bit_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_dv_next    = 1'b0;
    w_pe_next    = 1'b0;
    w_se_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!RX_IN) begin
          w_next_state = START;
          w_start      = 1'b1;
        end
      end
      START: begin
        if (w_last) w_next_state = w_bit ? IDLE : DATA;
      end
      DATA: begin
        if (w_last && (r_bit_cnt == LAST_BIT)) w_next_state = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (w_last) w_next_state = STOP;
      end
      STOP: begin
        if (w_last) begin
          if (!w_bit)          w_se_next = 1'b1;
          else if (r_par_fail) w_pe_next = 1'b1;
          else                 w_dv_next = 1'b1;
          // A low line on the final stop clock is the next frame's start bit.
          if (!RX_IN) begin
            w_next_state = START;
            w_start      = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_dv       <= 1'b0;
      r_pe       <= 1'b0;
      r_se       <= 1'b0;
    end else begin
      r_dv <= w_dv_next;
      r_pe <= w_pe_next;
      r_se <= w_se_next;
      if (w_dv_next) r_data <= r_shift;

      if (w_start) begin
        r_prescale <= Prescale;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (w_active) begin
        r_edge_cnt <= w_last ? '0 : (r_edge_cnt + W_ONE);
        if ((r_state == DATA) && w_last)
          r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : (r_bit_cnt + BIT_ONE);
      end else begin
        r_edge_cnt <= '0;
      end

      if ((r_state == DATA) && w_bit_ready)
        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};

      if (w_start)
        r_par_fail <= 1'b0;
      else if ((r_state == PARITY) && w_bit_ready)
        r_par_fail <= (w_bit != ((^r_shift) ^ r_par_typ));
    end
  end

  assign P_DATA     = r_data;
  assign data_valid = r_dv;
  assign par_err    = r_pe;
  assign stp_err    = r_se;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of frames with hand-computed results, plus
// sequences for start glitch, back-to-back frames, mid-frame reset and mid-bit glitch.
module tb_uart_rx;

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] d;
    bit         pb;
    bit         sb;
    int         kind;      // 0 data_valid, 1 par_err, 2 stp_err
    logic [7:0] exp_data;  // P_DATA after the frame
    int         exp_lat;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int tests;
  int fails;
  int cyc;
  int dv_cnt, pe_cnt, se_cnt;
  int dv_cyc, dv_cyc_prev, pe_cyc, se_cyc;
  int bad_strobe_cnt;
  logic [2:0] prev_strobes;

  vec_t vecs[10];

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
    dv_cyc = 0; dv_cyc_prev = 0; pe_cyc = 0; se_cyc = 0;
    bad_strobe_cnt = 0;
    prev_strobes = 3'b000;
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt      <= dv_cnt + 1;
      dv_cyc      <= cyc;
      dv_cyc_prev <= dv_cyc;
    end
    if (par_err) begin
      pe_cnt <= pe_cnt + 1;
      pe_cyc <= cyc;
    end
    if (stp_err) begin
      se_cnt <= se_cnt + 1;
      se_cyc <= cyc;
    end
    if ((int'(data_valid) + int'(par_err) + int'(stp_err)) > 1 ||
        ((prev_strobes & {data_valid, par_err, stp_err}) != 3'b000))
      bad_strobe_cnt <= bad_strobe_cnt + 1;
    prev_strobes <= {data_valid, par_err, stp_err};
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drives one whole frame, one line value per clock; gbit/gclk invert a single clock.
  task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                            input bit pb, input bit sb, input int gbit, input int gclk,
                            output int sc);
    logic [10:0] bits;
    int          n;
    logic        v;
    bits      = 11'h7FF;
    n         = pe ? 11 : 10;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pe) bits[9] = pb;
    bits[n-1] = sb;
    sc        = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        v = bits[k];
        if (k == gbit && j == gclk) v = ~v;
        RX_IN = v;
        if (k == 0 && j == 0) begin
          PAR_EN   = pe;
          PAR_TYP  = pt;
          Prescale = 6'(p);
          sc       = cyc + 1;
        end
      end
    end
  endtask

  task automatic line_idle(input int n);
    @(negedge clk);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int sc, sc2, dv0, pe0, se0, lat;
    tests = 0;
    fails = 0;

    //             p   pe pt data   pb sb kind exp_data lat
    vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 8'hA5, 80};
    vecs[1] = '{16, 1'b1, 1'b0, 8'h37, 1'b1, 1'b1, 0, 8'h37, 176};
    vecs[2] = '{16, 1'b1, 1'b0, 8'h37, 1'b0, 1'b1, 1, 8'h37, 176};
    vecs[3] = '{32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2, 8'h37, 320};
    vecs[4] = '{16, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 0, 8'hC3, 176};
    vecs[5] = '{8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1, 8'hC3, 88};
    vecs[6] = '{32, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 8'hFF, 352};
    vecs[7] = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 2, 8'hFF, 80};
    vecs[8] = '{8,  1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 2, 8'hFF, 88};
    vecs[9] = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 0, 8'h3C, 160};

    rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_p_data", int'(P_DATA), 0);
    check("reset_strobes", int'({data_valid, par_err, stp_err}), 0);

    foreach (vecs[i]) begin
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d, vecs[i].pb, vecs[i].sb, -1, -1, sc);
      line_idle(2 * vecs[i].p);
      check($sformatf("vec%0d_dv", i), dv_cnt - dv0, int'(vecs[i].kind == 0));
      check($sformatf("vec%0d_pe", i), pe_cnt - pe0, int'(vecs[i].kind == 1));
      check($sformatf("vec%0d_se", i), se_cnt - se0, int'(vecs[i].kind == 2));
      check($sformatf("vec%0d_data", i), int'(P_DATA), int'(vecs[i].exp_data));
      lat = (vecs[i].kind == 0) ? dv_cyc - sc : (vecs[i].kind == 1) ? pe_cyc - sc : se_cyc - sc;
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      $display("[TB] vec %0d P=%0d pe=%0d pt=%0d data=%02h kind=%0d P_DATA=%02h lat=%0d",
               i, vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d, vecs[i].kind, P_DATA, lat);
    end

    // Short low pulse on an idle line: false start, no strobes, then a clean frame.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    @(negedge clk);
    RX_IN = 1'b0; Prescale = 6'd16; PAR_EN = 1'b0;
    repeat (3) @(negedge clk);
    RX_IN = 1'b1;
    repeat (40) @(negedge clk);
    check("false_start_strobes", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, -1, sc);
    line_idle(32);
    check("after_false_start_dv", dv_cnt - dv0, 1);
    check("after_false_start_data", int'(P_DATA), 8'h55);
    $display("[TB] false start then 0x55: P_DATA=%02h", P_DATA);

    // Back-to-back frames with no idle gap.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, -1, -1, sc);
    send_frame(8, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, -1, -1, sc2);
    line_idle(16);
    check("b2b_dv_count", dv_cnt - dv0, 2);
    check("b2b_errors", (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("b2b_spacing", dv_cyc - dv_cyc_prev, 80);
    check("b2b_first_latency", dv_cyc_prev - sc, 80);
    check("b2b_data", int'(P_DATA), 8'h22);
    $display("[TB] back-to-back 0x11,0x22: spacing=%0d P_DATA=%02h", dv_cyc - dv_cyc_prev, P_DATA);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-clock low glitch on the middle sample of data bit 3 (frame bit 4).
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 4, 5, sc);
    line_idle(16);
    check("vote_dv", dv_cnt - dv0, 1);
    check("vote_data", int'(P_DATA), 8'hFF);
    $display("[TB] majority glitch 0xFF: P_DATA=%02h", P_DATA);
`endif

    // Reset in the middle of a frame's data bits, then a clean frame.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    @(negedge clk);
    RX_IN = 1'b0; Prescale = 6'd8; PAR_EN = 1'b0;
    repeat (8) @(negedge clk);
    RX_IN = 1'b0;
    repeat (8) @(negedge clk);
    RX_IN = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0; RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("reset_mid_frame_strobes", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("reset_mid_frame_p_data", int'(P_DATA), 0);
    send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, -1, sc);
    line_idle(16);
    check("post_reset_dv", dv_cnt - dv0, 1);
    check("post_reset_errors", (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("post_reset_data", int'(P_DATA), 8'h5A);
    $display("[TB] reset mid-frame then 0x5A: P_DATA=%02h", P_DATA);

    check("strobe_exclusive_one_cycle", bad_strobe_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
